// File: rtl/au_lead_sign_norm_seq.sv
// ---------------------------------------------------------------------------
// au_lead_sign_norm_seq
//
// Multi-cycle normalizer for two's-complement words. It counts the redundant
// sign bits below the MSB, looking at SEG bits per clock, and left-shifts the
// word until a[WIDTH-1] != a[WIDTH-2]. The all-zeros and all-ones inputs stop
// after WIDTH-1 shifts.
//
// Handshake: a transfer on either side happens on the rising clock edge where
// valid and ready are both high. in_ready is high only in IDLE. out_valid is
// high only in DONE. While out_valid is high and out_ready is low, every out_*
// signal holds its value. One operation is in flight at a time. After each
// output handshake there is one IDLE cycle before the next input is accepted.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous, active-high reset
//   in_valid     in_data is valid
//   in_ready     block can accept in_data (state == IDLE)
//   in_data      signed input word
//   out_valid    result is valid (state == DONE)
//   out_ready    consumer accepts the result
//   out_data     in_data << out_shift, with zeros shifted in
//   out_shift    number of redundant sign bits n (0 .. WIDTH-1)
//   out_pos      one-hot, bit (WIDTH-1-n) set
//   out_allsign  input was all zeros or all ones (n == WIDTH-1)
// ---------------------------------------------------------------------------
module au_lead_sign_norm_seq #(
  parameter  int WIDTH = 16,
  parameter  int SEG   = 4,
  localparam int SW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [SW-1:0]    out_shift,
  output logic [WIDTH-1:0] out_pos,
  output logic             out_allsign
);

  // Illegal parameter combinations stop elaboration.
  if ((WIDTH < 2) || (SEG < 1) || (SEG > WIDTH - 1)) begin : g_bad_param
    $error("au_lead_sign_norm_seq: illegal WIDTH=%0d / SEG=%0d", WIDTH, SEG);
  end

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] w;
  logic [SW-1:0]    cnt;

  // Scan datapath signals
  int               r;
  int               rem;
  int               step;
  int               cnt_sum;
  logic             run;
  logic             scan_last;
  logic [WIDTH-1:0] w_next;
  logic [SW-1:0]    cnt_next;

  // r is the length of the run of bits that match the sign bit. The run starts
  // at w[WIDTH-2] and is limited to SEG bits. SEG <= WIDTH-1, so the window
  // always stays inside the word. The step is capped at the number of bits
  // still available (rem), so the total shift never goes past WIDTH-1.
  always_comb begin
    run = 1'b1;
    r   = 0;
    for (int k = 0; k < SEG; k++) begin
      if (run && (w[WIDTH-2-k] == w[WIDTH-1])) begin
        r = r + 1;
      end else begin
        run = 1'b0;
      end
    end
    rem       = (WIDTH - 1) - int'(cnt);
    step      = (r < rem) ? r : rem;
    cnt_sum   = int'(cnt) + step;
    w_next    = w << step;
    cnt_next  = SW'(cnt_sum);
    // A short step means the run of sign bits ended inside the window. A sum
    // of WIDTH-1 means the word was all sign bits.
    scan_last = (step < SEG) || (cnt_sum == WIDTH - 1);
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid)  state_next = SCAN;
      SCAN:    if (scan_last) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Handshake outputs decoded from the state
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  // Working register, shift counter and registered results. The results are
  // loaded on the final SCAN cycle. They are not written in DONE, so they stay
  // stable while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w           <= '0;
      cnt         <= '0;
      out_data    <= '0;
      out_shift   <= '0;
      out_pos     <= '0;
      out_allsign <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            w   <= in_data;
            cnt <= '0;
          end
        end
        SCAN: begin
          w   <= w_next;
          cnt <= cnt_next;
          if (scan_last) begin
            out_data    <= w_next;
            out_shift   <= cnt_next;
            out_pos     <= ONE << ((WIDTH - 1) - cnt_sum);
            out_allsign <= (cnt_sum == WIDTH - 1);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_au_lead_sign_norm_seq.sv
// ---------------------------------------------------------------------------
// Testbench for au_lead_sign_norm_seq (WIDTH=16).
// The main instance uses SEG=4 and is driven with a table of directed
// vectors, followed by a stalled-consumer sequence and a reset asserted in the
// middle of a scan. Four more instances (SEG = 4, 1, 5, 15) each get random
// traffic. Their results are scored against a bit-serial leading-sign model.
// ---------------------------------------------------------------------------
module tb_au_lead_sign_norm_seq;

  localparam int NW = 2000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic rst_x;
  initial begin
    rst_x = 1'b1;
    #23 rst_x = 1'b0;
  end

  // ---------------- main DUT (SEG=4) ----------------
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [3:0]  out_shift;
  logic [15:0] out_pos;
  logic        out_allsign;

  au_lead_sign_norm_seq #(.WIDTH(16), .SEG(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_shift(out_shift),
    .out_pos(out_pos), .out_allsign(out_allsign)
  );

  // ---------------- scoreboard counters ----------------
  int checks = 0;
  int passed = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  // Reference model: count, one bit at a time, the bits below the MSB that
  // match it. Returns {data, shift, pos, allsign}.
  function automatic logic [36:0] model(input logic [15:0] a);
    int          n;
    bit          run;
    logic [15:0] d;
    logic [15:0] p;
    logic [3:0]  s;
    n   = 0;
    run = 1'b1;
    for (int i = 14; i >= 0; i--) begin
      if (run && (a[i] == a[15])) n++;
      else run = 1'b0;
    end
    d = a << n;
    p = 16'h0001 << (15 - n);
    s = n[3:0];
    return {d, s, p, (n == 15)};
  endfunction

  // ---------------- driver tasks ----------------
  // Sends one word, measures the number of clocks from acceptance to
  // out_valid, checks the result, then completes the output handshake.
  task automatic run_vec(input string tag, input logic [15:0] din, input logic [15:0] e_data,
                         input logic [3:0] e_shift, input logic [15:0] e_pos,
                         input logic e_all, input int e_lat);
    int cyc;
    @(negedge clk);
    in_data   = din;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    #1 check({tag, "_in_ready_idle"}, in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    check({tag, "_in_ready_busy"}, in_ready, 0);
    cyc = 1;
    while (!out_valid && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_latency"}, cyc, e_lat);
    check({tag, "_data"}, out_data, e_data);
    check({tag, "_shift"}, out_shift, e_shift);
    check({tag, "_pos"}, out_pos, e_pos);
    check({tag, "_allsign"}, out_allsign, e_all);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_valid_drop"}, out_valid, 0);
    check({tag, "_in_ready_back"}, in_ready, 1);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [15:0] din;
    logic [15:0] data;
    logic [3:0]  shift;
    logic [15:0] pos;
    logic        all;
    int          lat;
  } vec_t;

  vec_t vecs[12];

  initial begin
    int cyc;

    vecs[0]  = '{16'h0F00, 16'h7800, 4'd3,  16'h1000, 1'b0, 2};
    vecs[1]  = '{16'hFFFF, 16'h8000, 4'd15, 16'h0001, 1'b1, 5};
    vecs[2]  = '{16'h0000, 16'h0000, 4'd15, 16'h0001, 1'b1, 5};
    vecs[3]  = '{16'h4000, 16'h4000, 4'd0,  16'h8000, 1'b0, 2};
    vecs[4]  = '{16'h8000, 16'h8000, 4'd0,  16'h8000, 1'b0, 2};
    vecs[5]  = '{16'hFFF0, 16'h8000, 4'd11, 16'h0010, 1'b0, 4};
    vecs[6]  = '{16'h0001, 16'h4000, 4'd14, 16'h0002, 1'b0, 5};
    vecs[7]  = '{16'hC000, 16'h8000, 4'd1,  16'h4000, 1'b0, 2};
    vecs[8]  = '{16'h00FF, 16'h7F80, 4'd7,  16'h0100, 1'b0, 3};
    vecs[9]  = '{16'h0400, 16'h4000, 4'd4,  16'h0800, 1'b0, 3};
    vecs[10] = '{16'hF7FF, 16'hBFF8, 4'd3,  16'h1000, 1'b0, 2};
    vecs[11] = '{16'h0800, 16'h4000, 4'd3,  16'h1000, 1'b0, 2};

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_shift", out_shift, 0);
    check("rst_out_pos", out_pos, 0);
    check("rst_out_allsign", out_allsign, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      run_vec($sformatf("vec%0d", i), vecs[i].din, vecs[i].data, vecs[i].shift,
              vecs[i].pos, vecs[i].all, vecs[i].lat);
    end

    // Stalled consumer. A second word waits on in_valid the whole time.
    @(negedge clk);
    in_data   = 16'hFFF0;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    in_data = 16'h0F00;
    cyc = 1;
    while (!out_valid && cyc < 40) begin
      check("hold_in_ready_scan", in_ready, 0);
      @(negedge clk);
      cyc++;
    end
    check("hold_latency", cyc, 4);
    repeat (5) begin
      check("hold_valid", out_valid, 1);
      check("hold_in_ready", in_ready, 0);
      check("hold_data", out_data, 16'h8000);
      check("hold_shift", out_shift, 11);
      check("hold_pos", out_pos, 16'h0010);
      check("hold_allsign", out_allsign, 0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("hold_after_hs_valid", out_valid, 0);
    check("hold_after_hs_in_ready", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    check("hold_second_accepted", in_ready, 0);
    cyc = 1;
    while (!out_valid && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check("hold_second_latency", cyc, 2);
    check("hold_second_data", out_data, 16'h7800);
    check("hold_second_shift", out_shift, 3);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // Reset asserted between clock edges in the middle of a 4-cycle scan.
    @(negedge clk);
    in_data  = 16'h0001;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_in_ready", in_ready, 1);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_data", out_data, 0);
    check("midrst_out_shift", out_shift, 0);
    check("midrst_out_pos", out_pos, 0);
    check("midrst_out_allsign", out_allsign, 0);
    @(negedge clk);
    check("midrst_no_valid", out_valid, 0);
    rst = 1'b0;
    run_vec("after_rst", 16'h0F00, 16'h7800, 4'd3, 16'h1000, 1'b0, 2);

    // Wait for the random runs, with a bound.
    cyc = 0;
    while (!(g_seg[0].done && g_seg[1].done && g_seg[2].done && g_seg[3].done) && cyc < 100000) begin
      @(negedge clk);
      cyc++;
    end
    check("random_runs_finished",
          {g_seg[0].done, g_seg[1].done, g_seg[2].done, g_seg[3].done}, 4'hF);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  // ---------------- random traffic, one instance per SEG ----------------
  for (genvar g = 0; g < 4; g++) begin : g_seg
    localparam int S = (g == 0) ? 4 : (g == 1) ? 1 : (g == 2) ? 5 : 15;

    logic        iv;
    logic        ir;
    logic [15:0] id;
    logic        ov;
    logic        orr;
    logic [15:0] od;
    logic [3:0]  os;
    logic [15:0] op;
    logic        oa;
    logic        done = 1'b0;
    logic [36:0] exp_q[$];

    au_lead_sign_norm_seq #(.WIDTH(16), .SEG(S)) dut_r (
      .clk(clk), .rst(rst_x),
      .in_valid(iv), .in_ready(ir), .in_data(id),
      .out_valid(ov), .out_ready(orr),
      .out_data(od), .out_shift(os),
      .out_pos(op), .out_allsign(oa)
    );

    initial begin
      int          accepted;
      int          got;
      int          cyc;
      logic [15:0] rw;
      string       tag;
      tag      = $sformatf("rand_seg%0d", S);
      accepted = 0;
      got      = 0;
      cyc      = 0;
      iv       = 1'b0;
      id       = '0;
      orr      = 1'b0;
      while (rst_x) @(negedge clk);
      while (got < NW && cyc < 60000) begin
        @(negedge clk);
        cyc++;
        iv = (accepted < NW) && ($urandom_range(0, 1) == 1);
        if (iv) begin
          rw = 16'($urandom);
          id = 16'($signed(rw) >>> $urandom_range(0, 15));
        end
        orr = ($urandom_range(0, 3) != 0);
        #1;
        if (iv && ir) begin
          exp_q.push_back(model(id));
          accepted++;
        end
        if (ov && orr) begin
          if (exp_q.size() == 0) check({tag, "_unexpected_result"}, 1, 0);
          else check({tag, "_result"}, {od, os, op, oa}, exp_q.pop_front());
          got++;
        end
      end
      iv  = 1'b0;
      orr = 1'b0;
      check({tag, "_result_count"}, got, NW);
      check({tag, "_queue_empty"}, exp_q.size(), 0);
      done = 1'b1;
    end
  end

endmodule
